// File: rtl/fp16_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp16_mul_arbiter
//   Round-robin arbiter and sequencer that shares one FP16 multiplier core
//   among NUM_REQ requesters. One operand pair is accepted at a time. It is
//   issued to the core with a one-cycle start pulse, and the core's product
//   is returned to the granted requester over a valid/ready handshake.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Defined   : a watchdog counts WAIT cycles. After TIMEOUT_CYC+1 cycles with
//               no mul_done, the block returns FP16 qNaN (16'h7E00) with
//               rsp_err=1.
//   Undefined : WAIT has no time limit and rsp_err is tied to 0.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    per-requester operand valid
//   req_ready    per-requester accept (one-hot or zero, IDLE only)
//   req_a/req_b  packed operands, slice i = [16i+15:16i]
//   mul_start    one-cycle start pulse to the core
//   mul_a/mul_b  operands to the core, held from issue until the result
//   mul_done     core result strobe (sampled in WAIT only)
//   mul_result   core product {S,E[4:0],M[9:0]}
//   rsp_valid    per-requester response valid (one-hot or zero)
//   rsp_ready    per-requester response accept
//   rsp_data     shared response bus
//   rsp_err      response is a watchdog timeout
//   busy         high whenever the FSM is not in IDLE
//   op_count     completed response handshakes, wraps at 16 bits
// -----------------------------------------------------------------------------
module fp16_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic                   mul_start,
  output logic [15:0]            mul_a,
  output logic [15:0]            mul_b,
  input  logic                   mul_done,
  input  logic [15:0]            mul_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [15:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [15:0]            op_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("fp16_mul_arbiter: illegal NUM_REQ/IDX_W/TIMEOUT_CYC combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  localparam logic [15:0] QNAN = 16'h7E00;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        mul_a_q, mul_a_d;
  logic [15:0]        mul_b_q, mul_b_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic [15:0]        op_count_q, op_count_d;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  // Round-robin pick: first valid requester at or after last_grant+1, with wrap.
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_data_d   = rsp_data_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // ready is only ever raised toward a valid requester, so any selection is a handshake
        if (sel_found) begin
          req_ready    = NUM_REQ'(1) << sel_idx;
          mul_a_d      = req_a[{sel_idx, 4'b0000} +: 16];
          mul_b_d      = req_b[{sel_idx, 4'b0000} +: 16];
          idx_d        = sel_idx;
          last_grant_d = sel_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (mul_done) begin
          rsp_data_d = mul_result;
          state_d    = RESPOND;
`ifdef ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
          rsp_data_d = QNAN;
          rsp_err_d  = 1'b1;
          state_d    = RESPOND;
        end else begin
          to_cnt_d   = to_cnt_q + 1'b1;
`endif
        end
      end
      RESPOND: begin
        if (rsp_ready[idx_q]) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset -- rst_n is only sampled on the clock edge, so it
    // is not in the sensitivity list. Non-blocking assignments make every flop
    // sample pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_data_q   <= '0;
      op_count_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_data_q   <= rsp_data_d;
      op_count_q   <= op_count_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign mul_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESPOND) ? (NUM_REQ'(1) << idx_q) : '0;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
`ifdef ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp16_mul_arbiter
//   Directed bench for fp16_mul_arbiter (NUM_REQ=4). A behavioural core stub
//   answers each start pulse after stub_lat cycles with stub_res. Single
//   transactions come from a vector table; grant order, backpressure, reset
//   abort and the no-done case are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fp16_mul_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        mul_start;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic [15:0] mul_result;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [15:0] op_count;

  logic        stub_done;
  logic        man_done;
  logic        stub_en;
  int          stub_lat;
  logic [15:0] stub_res;

  int total;
  int bad;
  int exp_count;
  int n;
  int n_bad;

  assign mul_done = stub_done | man_done;

  fp16_mul_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYC(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core stub: done is high across the edge that ends cycle start+stub_lat.
  initial begin
    stub_done  = 1'b0;
    mul_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1 && stub_en) begin
        repeat (stub_lat) @(negedge clk);
        mul_result = stub_res;
        stub_done  = 1'b1;
        @(negedge clk);
        stub_done  = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic set_std_ops();
    for (int j = 0; j < 4; j++) begin
      req_a[16*j +: 16] = 16'h4000 | 16'(j);
      req_b[16*j +: 16] = 16'h3C00 | 16'(j);
    end
  endtask

  // One full transaction, entered just after a negedge while the FSM is idle.
  task automatic do_txn(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input int lat, input bit drop,
                        input logic [3:0] raise, input int hold);
    logic [3:0] oh;
    int cnt;
    int unstable;
    oh       = 4'b0001 << idx;
    stub_res = res;
    stub_lat = lat;
    #1;
    cnt = 0;
    while (req_ready == 4'b0000 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("grant", 32'(req_ready), 32'(oh));
    @(posedge clk);
    #1;
    if (drop) req_valid = 4'b0000;
    req_valid = req_valid | raise;
    @(negedge clk);
    check("start", 32'(mul_start), 1);
    check("mul_a", 32'(mul_a), 32'(a));
    check("mul_b", 32'(mul_b), 32'(b));
    check("busy", 32'(busy), 1);
    cnt      = 0;
    unstable = 0;
    while (rsp_valid == 4'b0000 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (mul_a !== a || mul_b !== b || req_ready !== 4'b0000) unstable++;
    end
    check("wait_hold", unstable, 0);
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_data", 32'(rsp_data), 32'(res));
    check("rsp_err", 32'(rsp_err), 0);
    if (hold > 0) begin
      rsp_ready = ~oh;
      unstable  = 0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (rsp_valid !== oh || rsp_data !== res || req_ready !== 4'b0000 ||
            op_count !== 16'(exp_count)) unstable++;
      end
      check("backpressure", unstable, 0);
    end
    rsp_ready = oh;
    @(posedge clk);
    #1;
    rsp_ready = 4'b0000;
    exp_count++;
    @(negedge clk);
    check("op_count", 32'(op_count), exp_count);
    check("rsp_drop", 32'(rsp_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic txn(input int idx, input bit drop, input logic [3:0] raise, input int hold);
    do_txn(idx, 16'h4000 | 16'(idx), 16'h3C00 | 16'(idx), 16'h5000 | 16'(idx), 2, drop, raise, hold);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
    int          idx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    total = 0; bad = 0; exp_count = 0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    man_done = 1'b0; stub_en = 1'b1; stub_lat = 1; stub_res = '0;

    // Grant expectations assume the sequence runs straight from reset
    // (last_grant starts at 3).
    vecs[0] = '{4'b0010, 16'h3C00, 16'h4000, 16'h4000, 5, 1};
    vecs[1] = '{4'b1001, 16'h4200, 16'h4400, 16'h4A00, 1, 3};
    vecs[2] = '{4'b1001, 16'hC000, 16'h3800, 16'hBC00, 2, 0};
    vecs[3] = '{4'b1100, 16'h3555, 16'h3C00, 16'h3555, 3, 2};
    vecs[4] = '{4'b0011, 16'h7BFF, 16'h3C00, 16'h7BFF, 1, 0};
    vecs[5] = '{4'b0001, 16'h0000, 16'h4500, 16'h0000, 4, 0};
    vecs[6] = '{4'b1000, 16'h4900, 16'h4900, 16'h5640, 1, 3};

    do_reset();
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_op_count", 32'(op_count), 0);

    // Table: single transactions, other slices hold decoy operands.
    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 4; j++) begin
        req_a[16*j +: 16] = (j == vecs[v].idx) ? vecs[v].a : (16'hBAD0 | 16'(j));
        req_b[16*j +: 16] = (j == vecs[v].idx) ? vecs[v].b : (16'hB0B0 | 16'(j));
      end
      req_valid = vecs[v].valid;
      do_txn(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].lat, 1'b1, 4'b0000, 0);
    end

    // All four requesting from reset: 0,1,2,3 then 0 again.
    do_reset();
    set_std_ops();
    req_valid = 4'b1111;
    txn(0, 1'b0, 4'b0000, 0);
    txn(1, 1'b0, 4'b0000, 0);
    txn(2, 1'b0, 4'b0000, 0);
    txn(3, 1'b0, 4'b0000, 0);
    txn(0, 1'b1, 4'b0000, 0);

    // Fairness: 0 and 2 alternate; 3 joins during a transaction for 0.
    do_reset();
    req_valid = 4'b0101;
    txn(0, 1'b0, 4'b0000, 0);
    txn(2, 1'b0, 4'b0000, 0);
    txn(0, 1'b0, 4'b0000, 0);
    txn(2, 1'b0, 4'b0000, 0);
    txn(0, 1'b0, 4'b1000, 0);
    txn(2, 1'b0, 4'b0000, 0);
    txn(3, 1'b0, 4'b0000, 0);
    txn(0, 1'b1, 4'b0000, 0);

    // Backpressure for 7 cycles while requester 2 is already waiting.
    req_valid = 4'b0010;
    txn(1, 1'b1, 4'b0100, 7);
    txn(2, 1'b1, 4'b0000, 0);

    // Reset in WAIT; the core's late done must not produce a response.
    req_valid = 4'b0001;
    stub_lat  = 10;
    stub_res  = 16'h1234;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("d_start", 32'(mul_start), 1);
    repeat (2) @(negedge clk);
    check("d_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("d_rst_busy", 32'(busy), 0);
    check("d_rst_op_count", 32'(op_count), 0);
    check("d_rst_mul_a", 32'(mul_a), 0);
    check("d_rst_rsp_data", 32'(rsp_data), 0);
    rst_n = 1'b1;
    exp_count = 0;
    n_bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) n_bad++;
    end
    check("d_ignore_done", n_bad, 0);
    req_valid = 4'b0011;
    txn(0, 1'b1, 4'b0000, 0);

    // Core never answers.
    stub_en   = 1'b0;
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("e_grant", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("e_start", 32'(mul_start), 1);
`ifdef ARB_TIMEOUT_EN
    n_bad = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) n_bad++;
    end
    check("e_no_early_rsp", n_bad, 0);
    @(negedge clk);
    check("e_to_valid", 32'(rsp_valid), 32'h4);
    check("e_to_data", 32'(rsp_data), 32'h7E00);
    check("e_to_err", 32'(rsp_err), 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("e_late_data", 32'(rsp_data), 32'h7E00);
    check("e_late_err", 32'(rsp_err), 1);
    check("e_late_valid", 32'(rsp_valid), 32'h4);
    rsp_ready = 4'b0100;
    @(posedge clk);
    #1;
    rsp_ready = 4'b0000;
    exp_count++;
    @(negedge clk);
    check("e_op_count", 32'(op_count), exp_count);
    check("e_idle", 32'(busy), 0);
`else
    n_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b1 || rsp_valid !== 4'b0000 || rsp_err !== 1'b0) n_bad++;
    end
    check("e_stuck_busy", n_bad, 0);
    do_reset();
    #1;
    check("e_recover", 32'(busy), 0);
`endif
    stub_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
